// File: rtl/conv_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_stream_pkg
// Description : Shared sizes, widths, FSM state type and throttle LFSR seed
//               for the convolution stream host.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_stream_pkg;

    localparam int DATA_WIDTH_X = 8;
    localparam int DATA_WIDTH_F = 8;
    localparam int X_SIZE       = 128;
    localparam int F_SIZE       = 32;
    localparam int ACC_SIZE     = 21;
    localparam int Y_SIZE       = X_SIZE - F_SIZE + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage
`default_nettype wire

// File: rtl/stream_src_chan.sv
`default_nettype none
// ============================================================================
// Module      : stream_src_chan
// Description : Valid/ready source channel. Walks a beat counter from 0 to
//               SIZE, presenting addr = counter to an external buffer. Valid
//               is raised while active and beats remain; once raised it is
//               held until accepted. A set gate input suppresses a new beat
//               but never withdraws one already offered.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               clear            - zero the counter (job launch)
//               active           - channel may send (host in SEND)
//               gate             - suppress starting a new beat this cycle
//               ready            - sink ready
//               valid            - source valid
//               addr             - buffer index of the beat on offer
//               all_sent         - counter has reached SIZE
// Revision    : 1.0 - initial release
// ============================================================================
module stream_src_chan #(
    parameter  int SIZE = 128,
    localparam int CW   = $clog2(SIZE + 1),
    localparam int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          active,
    input  logic          gate,
    input  logic          ready,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic          all_sent
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pend_q;
    logic          pend_d;
    logic          more;

    always_comb begin
        more     = int'(cnt_q) < SIZE;
        // pend_q marks a beat offered last cycle and not yet taken, so the
        // gate cannot drop it mid-handshake.
        valid    = active && more && (pend_q || !gate);
        addr     = cnt_q[AW-1:0];
        all_sent = !more;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        if (clear) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (valid && ready) begin
                cnt_d = cnt_q + 1'b1;
            end
            pend_d = valid && !ready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_stream_host.sv
`default_nettype none
// ============================================================================
// Module      : conv_stream_host
// Description : Host front end for the convolution engine. Holds one X and
//               one F vector written through the cfg port, streams them out
//               as a valid/ready master on start, and captures the Y results
//               into a buffer read back combinationally by address.
// Ports       : clk, reset                 - clock, sync active-high reset
//               cfg_wr_en/sel/addr/wdata   - X (sel=0) / F (sel=1) writes,
//                                            honoured only while idle
//               start                      - launch a job (pulse)
//               busy, done                 - job in progress / completion
//               m_valid_x/m_data_x/m_ready_x - X stream master
//               m_valid_f/m_data_f/m_ready_f - F stream master
//               s_valid_y/s_data_y/s_ready_y - Y stream slave
//               res_addr, res_data         - result readback
//               y_count                    - results captured this job
// Options     : CONV_STREAM_HOST_THROTTLE_EN - LFSR-driven throttling of
//               X/F valid and Y ready for stress testing.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_stream_host #(
    parameter  int DATA_WIDTH_X = conv_stream_pkg::DATA_WIDTH_X,
    parameter  int DATA_WIDTH_F = conv_stream_pkg::DATA_WIDTH_F,
    parameter  int X_SIZE       = conv_stream_pkg::X_SIZE,
    parameter  int F_SIZE       = conv_stream_pkg::F_SIZE,
    parameter  int ACC_SIZE     = conv_stream_pkg::ACC_SIZE,
    localparam int Y_SIZE       = X_SIZE - F_SIZE + 1,
    localparam int XAW          = $clog2(X_SIZE),
    localparam int FAW          = $clog2(F_SIZE),
    localparam int YAW          = $clog2(Y_SIZE),
    localparam int YCW          = $clog2(Y_SIZE + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_wr_en,
    input  logic                    cfg_sel,
    input  logic [XAW-1:0]          cfg_addr,
    input  logic [DATA_WIDTH_X-1:0] cfg_wdata,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    m_valid_x,
    output logic [DATA_WIDTH_X-1:0] m_data_x,
    input  logic                    m_ready_x,
    output logic                    m_valid_f,
    output logic [DATA_WIDTH_F-1:0] m_data_f,
    input  logic                    m_ready_f,
    input  logic                    s_valid_y,
    input  logic [ACC_SIZE-1:0]     s_data_y,
    output logic                    s_ready_y,
    input  logic [YAW-1:0]          res_addr,
    output logic [ACC_SIZE-1:0]     res_data,
    output logic [YCW-1:0]          y_count
);

    import conv_stream_pkg::state_e;
    import conv_stream_pkg::IDLE;
    import conv_stream_pkg::SEND;
    import conv_stream_pkg::COLLECT;
    import conv_stream_pkg::DONE;

    state_e                  state_q;
    state_e                  state_d;
    logic                    start_accept;
    logic                    in_send;
    logic                    in_collect;

    logic [DATA_WIDTH_X-1:0] x_buf_q   [X_SIZE];
    logic [DATA_WIDTH_F-1:0] f_buf_q   [F_SIZE];
    logic [ACC_SIZE-1:0]     res_buf_q [Y_SIZE];

    logic [XAW-1:0]          x_addr;
    logic [FAW-1:0]          f_addr;
    logic                    x_all;
    logic                    f_all;

    logic [YCW-1:0]          y_cnt_q;
    logic [YCW-1:0]          y_cnt_d;
    logic                    y_pend_q;
    logic                    y_pend_d;
    logic                    y_more;
    logic                    y_fire;

    logic                    gate_x;
    logic                    gate_f;
    logic                    gate_y;

    // ------------------------------------------------------------------
    // Optional throttle source
    // ------------------------------------------------------------------
`ifdef CONV_STREAM_HOST_THROTTLE_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        // Fibonacci LFSR, taps 16/14/13/11 (maximal length)
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= conv_stream_pkg::LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign gate_x = lfsr_q[0];
    assign gate_f = lfsr_q[1];
    assign gate_y = lfsr_q[2];
`else
    assign gate_x = 1'b0;
    assign gate_f = 1'b0;
    assign gate_y = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)          state_d = SEND;
            SEND:    if (x_all && f_all) state_d = COLLECT;
            COLLECT: if (!y_more)        state_d = DONE;
            DONE:                        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        in_send      = (state_q == SEND);
        in_collect   = (state_q == COLLECT);
        start_accept = (state_q == IDLE) && start;
    end

    // ------------------------------------------------------------------
    // X / F source channels
    // ------------------------------------------------------------------
    stream_src_chan #(
        .SIZE     (X_SIZE)
    ) u_x_chan (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_accept),
        .active   (in_send),
        .gate     (gate_x),
        .ready    (m_ready_x),
        .valid    (m_valid_x),
        .addr     (x_addr),
        .all_sent (x_all)
    );

    stream_src_chan #(
        .SIZE     (F_SIZE)
    ) u_f_chan (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_accept),
        .active   (in_send),
        .gate     (gate_f),
        .ready    (m_ready_f),
        .valid    (m_valid_f),
        .addr     (f_addr),
        .all_sent (f_all)
    );

    assign m_data_x = x_buf_q[x_addr];
    assign m_data_f = f_buf_q[f_addr];

    // ------------------------------------------------------------------
    // Y sink: accepted in SEND as well, so an engine that streams results
    // before the last X/F beat is still served.
    // ------------------------------------------------------------------
    always_comb begin
        y_more    = int'(y_cnt_q) < Y_SIZE;
        s_ready_y = (in_send || in_collect) && y_more && (y_pend_q || !gate_y);
        y_fire    = s_ready_y && s_valid_y;
        y_cnt_d   = y_cnt_q;
        y_pend_d  = y_pend_q;
        if (start_accept) begin
            y_cnt_d  = '0;
            y_pend_d = 1'b0;
        end else begin
            if (y_fire) begin
                y_cnt_d = y_cnt_q + 1'b1;
            end
            y_pend_d = s_ready_y && !s_valid_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_cnt_q  <= '0;
            y_pend_q <= 1'b0;
        end else begin
            y_cnt_q  <= y_cnt_d;
            y_pend_q <= y_pend_d;
        end
    end

    assign y_count = y_cnt_q;

    // ------------------------------------------------------------------
    // Storage. Not reset: contents survive reset and partial jobs.
    // A cfg write coinciding with start lands before the first beat is read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cfg_wr_en && (state_q == IDLE)) begin
            if (!cfg_sel) begin
                x_buf_q[cfg_addr] <= cfg_wdata;
            end else begin
                f_buf_q[cfg_addr[FAW-1:0]] <= cfg_wdata[DATA_WIDTH_F-1:0];
            end
        end
        if (y_fire) begin
            res_buf_q[y_cnt_q[YAW-1:0]] <= s_data_y;
        end
    end

    assign res_data = (int'(res_addr) < Y_SIZE) ? res_buf_q[res_addr] : '0;

endmodule
`default_nettype wire
